// File: rtl/uart_pkg.sv
// uart_pkg: shared configuration field offsets and arbiter state encodings
package uart_pkg;
  localparam int CONF_W     = 5;
  localparam int PARITY_BIT = 0;
  localparam int STOP_LSB   = 1;
  localparam int DATA_LSB   = 3;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;
  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP
  } arb_state_e;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin picker starting at ptr_i
module rr_priority_select #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // scan from farthest to nearest so the requester closest to ptr_i wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[IW'((int'(ptr_i) + k) % N)]) begin
        gnt_o = '0;
        gnt_o[IW'((int'(ptr_i) + k) % N)] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART tx engine among NUM_CH requesters
module uart_tx_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int MAX_UART_DATA_W = 8,
  parameter int CONF_W          = 5,
  parameter int GAP_TICKS       = 0,
  localparam int ChIdW = $clog2(NUM_CH)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic                              baud_en_i,
  input  logic [NUM_CH-1:0]                 req_valid_i,
  output logic [NUM_CH-1:0]                 req_ready_o,
  input  logic [NUM_CH*MAX_UART_DATA_W-1:0] req_data_i,
  input  logic [NUM_CH*CONF_W-1:0]          req_conf_i,
  output logic                              tx_en_o,
  output logic                              tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]        tx_data_o,
  output logic [CONF_W-1:0]                 tx_conf_o,
  input  logic                              tx_busy_i,
  input  logic                              tx_done_i,
  output logic [ChIdW-1:0]                  grant_id_o,
  output logic                              frame_done_o,
  output logic [ChIdW-1:0]                  frame_done_id_o,
  output logic                              busy_o
);
  import uart_pkg::*;
  arb_state_e                 state_q, state_d;
  logic [ChIdW-1:0]           ptr_q, ptr_d, grant_q, grant_d, done_id_q, done_id_d, win_idx;
  logic [MAX_UART_DATA_W-1:0] data_q, data_d, data_sel;
  logic [CONF_W-1:0]          conf_q, conf_d, conf_sel;
  logic [7:0]                 gap_q, gap_d;
  logic                       tx_en_q, tx_en_d, done_q, done_d;
  logic [NUM_CH-1:0]          win_oh;
  logic                       any_req, grant;

  rr_priority_select #(.N(NUM_CH)) u_sel (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  assign grant           = state_q == IDLE && en_i && any_req;
  assign req_ready_o     = (grant && !rst_i) ? win_oh : '0;
  assign tx_start_o      = state_q == START;
  assign busy_o          = state_q != IDLE;
  assign tx_en_o         = tx_en_q;
  assign tx_data_o       = data_q;
  assign tx_conf_o       = conf_q;
  assign grant_id_o      = grant_q;
  assign frame_done_o    = done_q;
  assign frame_done_id_o = done_id_q;

  // mux out the winner's frame using the one-hot grant
  always_comb begin
    data_sel = '0;
    conf_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_oh[i]) begin
        data_sel = req_data_i[i*MAX_UART_DATA_W +: MAX_UART_DATA_W];
        conf_sel = req_conf_i[i*CONF_W +: CONF_W];
      end
    end
  end

  // next-state, frame capture, pointer advance and gap counting
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    conf_d    = conf_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    tx_en_d   = en_i;
    case (state_q)
      IDLE: if (grant) begin
        state_d = START;
        grant_d = win_idx;
        ptr_d   = (win_idx == ChIdW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
        data_d  = data_sel;
        conf_d  = conf_sel;
      end
      START: if (tx_busy_i) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done_i) begin
        done_d    = 1'b1;
        done_id_d = grant_q;
        gap_d     = '0;
        state_d   = (GAP_TICKS > 0) ? GAP : IDLE;
      end
      GAP: if (baud_en_i) begin
        gap_d   = gap_q + 8'd1;
        state_d = (gap_q == 8'(GAP_TICKS - 1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      conf_q    <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      conf_q    <= conf_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      tx_en_q   <= tx_en_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench with a behavioural tx engine and arbiter model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, CW = 5, GAP = 3;
  logic clk = 0, rst = 0, en = 0, baud = 0, busy = 0, done = 0;
  logic [N-1:0] valid = '0;
  logic [N*W-1:0] data = '0;
  logic [N*CW-1:0] conf = '0;
  logic [N-1:0] ready;
  logic tx_en, tx_start, fd, abusy;
  logic [W-1:0] tx_data;
  logic [CW-1:0] tx_conf;
  logic [1:0] gid, fd_id;
  logic [N-1:0] nvalid = '0;
  logic [N*W-1:0] ndata = '0;
  logic [N*CW-1:0] nconf = '0;
  logic nen = 0;
  int checks = 0, failures = 0, cyc = 0;
  int owner = -1, ptr_m = 0, gap_left = 0, exp_fd_id = 0;
  bit started = 0, in_gap = 0, exp_fd = 0, prev_en = 0;
  logic [W-1:0] own_data;
  logic [CW-1:0] own_conf;
  int e_ph = 0, e_cnt = 0, d_cnt = 0;
  int grants[$], dones[$];
  int meas = -1, gcnt = 0;
  bit gact = 0;

  uart_tx_arbiter #(.NUM_CH(N), .MAX_UART_DATA_W(W), .CONF_W(CW), .GAP_TICKS(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .baud_en_i(baud),
    .req_valid_i(valid), .req_ready_o(ready), .req_data_i(data), .req_conf_i(conf),
    .tx_en_o(tx_en), .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_conf_o(tx_conf),
    .tx_busy_i(busy), .tx_done_i(done), .grant_id_o(gid),
    .frame_done_o(fd), .frame_done_id_o(fd_id), .busy_o(abusy)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic [N-1:0] exp_ready;
    int win;
    @(negedge clk);
    valid = nvalid; data = ndata; conf = nconf; en = nen;
    if (d_cnt > 0) begin d_cnt--; if (d_cnt == 0) done = 0; end
    case (e_ph)
      0: if (tx_start) begin
        if (done) begin done = 0; d_cnt = 0; end
        else begin e_ph = 1; e_cnt = $urandom_range(0, 2); end
      end
      1: if (e_cnt == 0) begin busy = 1; e_ph = 2; e_cnt = $urandom_range(3, 8); end
         else e_cnt--;
      default: begin
        e_cnt--;
        if (e_cnt == 0) begin busy = 0; done = 1; d_cnt = $urandom_range(2, 6); e_ph = 0; end
      end
    endcase
    baud = ($urandom_range(0, 2) == 0);
    #2;
    cyc++;
    exp_ready = '0;
    win = -1;
    if (owner < 0 && !in_gap && en && valid != 0) begin
      for (int k = 0; k < N; k++)
        if (win < 0 && valid[2'((ptr_m + k) % N)]) win = (ptr_m + k) % N;
      exp_ready[2'(win)] = 1'b1;
    end
    checks++;
    if (ready !== exp_ready) begin failures++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, exp_ready); end
    checks++;
    if (tx_en !== prev_en) begin failures++; $display("FAIL tx_en cyc=%0d got=%b exp=%b", cyc, tx_en, prev_en); end
    checks++;
    if (abusy !== (owner >= 0 || in_gap)) begin failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, abusy, owner >= 0 || in_gap); end
    checks++;
    if (fd !== exp_fd || (exp_fd && fd_id !== 2'(exp_fd_id))) begin
      failures++; $display("FAIL frame_done cyc=%0d got=%b/%0d exp=%b/%0d", cyc, fd, fd_id, exp_fd, exp_fd_id);
    end
    if (owner >= 0) begin
      checks++;
      if (tx_start !== !started || tx_data !== own_data || tx_conf !== own_conf || gid !== 2'(owner)) begin
        failures++;
        $display("FAIL hold cyc=%0d got start=%b data=%h conf=%b id=%0d exp start=%b data=%h conf=%b id=%0d",
                 cyc, tx_start, tx_data, tx_conf, gid, !started, own_data, own_conf, owner);
      end
    end
    if (ready != 0 && gact) begin meas = gcnt; gact = 0; end
    if (fd) begin gact = 1; gcnt = 0; dones.push_back(int'(fd_id)); end
    if (gact && baud) gcnt++;
    exp_fd = 0;
    if (in_gap) begin
      if (baud) begin gap_left--; if (gap_left == 0) in_gap = 0; end
    end else if (owner >= 0) begin
      if (!started) started = busy;
      else if (done) begin exp_fd = 1; exp_fd_id = owner; owner = -1; in_gap = GAP > 0; gap_left = GAP; end
    end
    if (win >= 0) begin
      owner = win; started = 0; ptr_m = (win + 1) % N;
      own_data = W'(data >> (win * W));
      own_conf = CW'(conf >> (win * CW));
      grants.push_back(win);
    end
    prev_en = en;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst = 1;
    #1;
    owner = -1; in_gap = 0; exp_fd = 0; ptr_m = 0; prev_en = 0; started = 0; gact = 0;
    busy = 0; done = 0; e_ph = 0; d_cnt = 0;
  endtask

  task automatic release_reset();
    nen = 0; nvalid = '0; en = 0; valid = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_grant(output int ch);
    int n0 = grants.size();
    int t = 0;
    while (grants.size() == n0 && t < 300) begin step(); t++; end
    checks++;
    if (grants.size() == n0) begin failures++; ch = -1; $display("FAIL wait_grant got=timeout exp=grant"); end
    else ch = grants[$];
  endtask

  task automatic wait_done(output int id);
    int n0 = dones.size();
    int t = 0;
    while (dones.size() == n0 && t < 300) begin step(); t++; end
    checks++;
    if (dones.size() == n0) begin failures++; id = -1; $display("FAIL wait_done got=timeout exp=frame_done"); end
    else id = dones[$];
  endtask

  task automatic drain();
    int t = 0;
    nvalid = '0;
    while ((owner >= 0 || in_gap) && t < 300) begin step(); t++; end
    step();
  endtask

  task automatic test_reset();
    assert_reset();
    en = 1; valid = '1;
    #1;
    checks++;
    if ({ready, tx_en, tx_start, tx_data, tx_conf, gid, fd, fd_id, abusy} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {ready, tx_en, tx_start, tx_data, tx_conf, gid, fd, fd_id, abusy});
    end
    release_reset();
    repeat (3) step();
  endtask

  task automatic test_single_frame();
    int ch, id;
    nen = 1; nvalid = 4'b0100;
    ndata = 32'h00A5_0000; nconf = 20'(5'b11000) << 10;
    wait_grant(ch);
    checks++;
    if (ch !== 2) begin failures++; $display("FAIL single_grant got=%0d exp=2", ch); end
    nvalid = '0;
    wait_done(id);
    checks++;
    if (id !== 2) begin failures++; $display("FAIL single_done_id got=%0d exp=2", id); end
    drain();
  endtask

  task automatic test_fairness();
    int ch, id;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    assert_reset();
    release_reset();
    nen = 1; nvalid = '1; ndata = $urandom; nconf = 20'($urandom);
    for (int i = 0; i < 5; i++) begin
      wait_grant(ch);
      checks++;
      if (ch !== exp_seq[i]) begin failures++; $display("FAIL fair_grant%0d got=%0d exp=%0d", i, ch, exp_seq[i]); end
      wait_done(id);
      checks++;
      if (id !== ch) begin failures++; $display("FAIL fair_done%0d got=%0d exp=%0d", i, id, ch); end
    end
    drain();
  endtask

  task automatic test_hold();
    int ch, id;
    nen = 1; nvalid = 4'b0001; ndata = 32'h0000_0055;
    wait_grant(ch);
    ndata = 32'h0000_003C;
    wait_done(id);
    checks++;
    if (tx_data !== 8'h55 || id !== 0) begin failures++; $display("FAIL hold_data got=%h/%0d exp=55/0", tx_data, id); end
    drain();
  endtask

  task automatic test_gap();
    int ch;
    nen = 1; nvalid = 4'b0010; meas = -1;
    wait_grant(ch);
    wait_grant(ch);
    checks++;
    if (meas !== GAP) begin failures++; $display("FAIL gap_ticks got=%0d exp=%0d", meas, GAP); end
    drain();
  endtask

  task automatic test_enable_drop();
    int ch, n0, g0, t;
    nen = 1; nvalid = 4'b0001;
    wait_grant(ch);
    t = 0;
    while (!started && t < 50) begin step(); t++; end
    nvalid = 4'b0010; nen = 0;
    n0 = dones.size(); g0 = grants.size();
    repeat (40) step();
    checks++;
    if (dones.size() != n0 + 1 || grants.size() != g0) begin
      failures++; $display("FAIL en_drop got=done%0d/grant%0d exp=done1/grant0", dones.size() - n0, grants.size() - g0);
    end
    nen = 1;
    wait_grant(ch);
    checks++;
    if (ch !== 1) begin failures++; $display("FAIL en_resume got=%0d exp=1", ch); end
    drain();
  endtask

  task automatic test_reset_mid();
    int ch, t;
    nen = 1; nvalid = 4'b0010;
    wait_grant(ch);
    t = 0;
    while (!started && t < 50) begin step(); t++; end
    step();
    assert_reset();
    checks++;
    if ({ready, tx_en, tx_start, tx_data, tx_conf, gid, fd, fd_id, abusy} !== '0) begin
      failures++; $display("FAIL reset_mid got=%b exp=0", {ready, tx_en, tx_start, tx_data, tx_conf, gid, fd, fd_id, abusy});
    end
    release_reset();
    nen = 1; nvalid = '1;
    wait_grant(ch);
    checks++;
    if (ch !== 0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", ch); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      nvalid = 4'($urandom);
      ndata = $urandom;
      nconf = 20'($urandom);
      nen = $urandom_range(0, 9) != 0;
      step();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fairness();
    test_hold();
    test_gap();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmit engine (tx_module) between NUM_CH requesters.
- Each requester offers one frame via a valid/ready handshake. The arbiter captures the frame data and configuration, then drives the tx engine start/data/conf inputs.
- It holds those inputs stable until the engine reports completion, and returns a per-frame done pulse tagged with the channel ID.
- Sits between the register/FIFO front-end and tx_module in the UART top level.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- MAX_UART_DATA_W, 8, frame data width.
- CONF_W, 5, tx configuration width {data_len[1:0], stop[1:0], parity_en}.
- GAP_TICKS, 0, idle baud ticks inserted between consecutive frames (0..255).
- ChIdW (local), $clog2(NUM_CH), channel ID width.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- en_i  in  1  arbiter/tx enable
- baud_en_i  in  1  baud tick, shared with tx_module
- req_valid_i  in  NUM_CH  per-channel frame valid
- req_ready_o  out  NUM_CH  per-channel accept, one-hot pulse
- req_data_i  in  NUM_CH*MAX_UART_DATA_W  flattened data, channel 0 in LSBs
- req_conf_i  in  NUM_CH*CONF_W  flattened configuration, channel 0 in LSBs
- tx_en_o  out  1  to tx_module tx_en_i
- tx_start_o  out  1  to tx_module tx_start_i
- tx_data_o  out  MAX_UART_DATA_W  to tx_module tx_data_i
- tx_conf_o  out  CONF_W  to tx_module tx_conf_i
- tx_busy_i  in  1  from tx_module busy_o
- tx_done_i  in  1  from tx_module tx_done_o
- grant_id_o  out  ChIdW  channel currently owning the engine
- frame_done_o  out  1  one-clk pulse when a frame completes
- frame_done_id_o  out  ChIdW  channel of the completed frame, valid with frame_done_o
- busy_o  out  1  arbiter not in IDLE

Behaviour:
Reset and enable
- Reset is asynchronous, active-high, on rst_i; clock is clk_i.
- On reset, all outputs are 0: tx_data_o=0, tx_conf_o=0, grant_id_o=0, state=IDLE, priority pointer=0, gap counter=0.
- tx_en_o is a registered copy of en_i.

FSM (clk_i domain; only GAP advances on baud_en_i)
- IDLE: if en_i=1 and any req_valid_i=1, select the winner by round-robin starting at the pointer.
  - Same clk: pulse req_ready_o[winner].
  - Next edge: latch data/conf into the tx_data_o/tx_conf_o registers, set grant_id_o, pointer <= winner+1 (mod NUM_CH), go to START.
- START: tx_start_o=1. Stay until tx_busy_i=1, then tx_start_o=0 and go to WAIT_DONE.
- WAIT_DONE: stay until tx_done_i=1. Then:
  - pulse frame_done_o with frame_done_id_o=grant_id_o for one clk;
  - go to GAP if GAP_TICKS>0, else to IDLE.
- GAP: count baud_en_i ticks; after GAP_TICKS ticks, go to IDLE.

Handshake and hold rules
- Handshake completes on the clk where req_valid_i[i] & req_ready_o[i]. Exactly one ready bit is high, for exactly one clk, and only in IDLE.
- tx_data_o and tx_conf_o stay unchanged from the START entry until WAIT_DONE exits. The engine loads its configuration late, and it loads it over multiple clks.

Boundary conditions
- en_i low: no new grants. An in-flight frame (START/WAIT_DONE/GAP) completes normally. tx_en_o follows en_i.
- en_i dropped while in START: keep tx_start_o asserted until tx_busy_i. The engine in Idle still accepts.
- req_valid_i withdrawn before grant: ignored, no error.
- Pointer wrap: NUM_CH-1 -> 0.
- Single requester continuously valid: granted back-to-back.
- tx_done_i remains high for one baud period. Its stale high level must not complete the next frame: WAIT_DONE is entered only after tx_busy_i=1, and tx_module clears done before busy rises.
- Reset mid-frame: the arbiter returns to IDLE immediately. The tx engine is reset by the same rst_i.

Decomposition:
- Shared package uart_pkg:
  - CONF_W and conf field offsets (PARITY_BIT=0, STOP_LSB=1, DATA_LSB=3);
  - arbiter state encodings IDLE/START/WAIT_DONE/GAP as 2-bit localparams.
- One sub-module: rr_priority_select, a combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_req.

Test Plan:
- Single frame: ch2 valid, data 0xA5, conf 5'b11_00_0, GAP_TICKS=0.
  - Expect ready[2] one-clk pulse, tx_data_o=0xA5, tx_start_o held until tx_busy_i.
  - After tx_done_i, expect frame_done_o with id=2.
- Fairness: all 4 channels continuously valid.
  - Expect grant order 0,1,2,3,0. Each frame_done_id_o matches its grant.
- Hold check: change req_data_i[ch0] to 0x3C right after the grant of 0x55.
  - Expect tx_data_o=0x55 until frame_done_o.
  - The serial line, checked with the real tx_module, shows 0x55.
- Gap: GAP_TICKS=3, two back-to-back frames.
  - Expect exactly 3 baud_en_i ticks between frame_done_o and the next ready pulse.
- Enable drop: deassert en_i during WAIT_DONE with ch1 pending.
  - Expect the current frame to finish, no ready pulse while en_i=0, and ch1 granted after en_i=1.
- Reset mid-frame: assert rst_i in WAIT_DONE.
  - Expect all outputs 0 and state IDLE asynchronously, and grant resuming from pointer 0 after release.
